// File: rtl/fmap_pkg.sv
`default_nettype none
// ============================================================================
// fmap_pkg : shared constants, state encoding and helpers for the feature-map
//            ping-pong SRAM.
// Revision : 1.0
// ============================================================================
package fmap_pkg;

   localparam logic SramEnable  = 1'b1;
   localparam logic SramDisable = 1'b0;
   localparam logic SramRead    = 1'b0;
   localparam logic SramWrite   = 1'b1;
   localparam logic Finish      = 1'b1;
   localparam logic UnFinish    = 1'b0;

   localparam int DW_DEFAULT = 16;

   typedef enum logic {
      ACTIVE    = 1'b0,
      SWAP_PEND = 1'b1
   } fmap_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hffff) ? v : v + 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fmap_bank.sv
`default_nettype none
// ============================================================================
// fmap_bank : single-port synchronous RAM, DEPTH x DW, registered read that
//             holds its value between reads. Contents are never reset.
// Revision  : 1.0
// ============================================================================
module fmap_bank
   import fmap_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int AW    = 12,
   parameter int DW    = DW_DEFAULT
) (
   input  logic          clk,
   input  logic          i_en,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_q;

   always_ff @(posedge clk) begin
      if (i_en) begin
         if (i_we == SramWrite) begin
            r_mem[i_addr] <= i_wdata;
         end else begin
            r_q <= r_mem[i_addr];
         end
      end
   end

   assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/fmap_pingpong_sram.sv
`default_nettype none
// ============================================================================
// fmap_pingpong_sram : two-bank ping-pong feature-map store; one bank serves
//                      reads while the other takes writes, exchanged by swap.
// Optional macro     : FMAP_OOB_CHECK_EN (range check, sticky err_oob, and
//                      one-cycle swap deferral when an error hits the swap).
// Revision           : 1.0
// ============================================================================
module fmap_pingpong_sram
   import fmap_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int AW    = 12,
   parameter int DW    = DW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_rd_en,
   input  logic          i_rd_wea,
   input  logic [15:0]   i_rd_addr,
   output logic [DW-1:0] o_rd_data,
   input  logic          i_wr_en,
   input  logic          i_wr_wea,
   input  logic [15:0]   i_wr_addr,
   input  logic [DW-1:0] i_wr_data,
   input  logic          i_swap,
   output logic          o_swap_ack,
   output logic          o_bank_sel,
   output logic [15:0]   o_frame_words,
   output logic          o_err_oob
);

   fmap_state_e   r_state;
   fmap_state_e   w_state_nxt;
   logic          w_do_swap;

   logic          r_bank_sel;
   logic          r_swap_ack;
   logic [15:0]   r_wr_cnt;
   logic [15:0]   r_frame_words;
   logic          r_err_oob;
   logic          r_rd_bank;
   logic          r_rd_zero;

   logic          w_rd_fire;
   logic          w_wr_fire;
   logic          w_rd_oob;
   logic          w_wr_oob;
   logic          w_oob_evt;
   logic          w_rd_go;
   logic          w_wr_go;
   logic [AW-1:0] w_rd_idx;
   logic [AW-1:0] w_wr_idx;
   logic [15:0]   w_cnt_inc;

   logic          w_bank_en   [2];
   logic          w_bank_we   [2];
   logic [AW-1:0] w_bank_addr [2];
   logic [DW-1:0] w_bank_q    [2];

   assign w_rd_fire = (i_rd_en == SramEnable) && (i_rd_wea == SramRead);
   assign w_wr_fire = (i_wr_en == SramEnable) && (i_wr_wea == SramWrite);

`ifdef FMAP_OOB_CHECK_EN
   localparam logic [16:0] c_DEPTH = 17'(DEPTH);

   assign w_rd_oob  = ({1'b0, i_rd_addr} >= c_DEPTH);
   assign w_wr_oob  = ({1'b0, i_wr_addr} >= c_DEPTH);
   assign w_oob_evt = (w_rd_fire & w_rd_oob) | (w_wr_fire & w_wr_oob);
`else
   // Without the range check the upper address bits are simply discarded.
   logic w_unused_addr_hi;
   assign w_unused_addr_hi = ^{i_rd_addr[15:AW], i_wr_addr[15:AW]};

   assign w_rd_oob  = 1'b0;
   assign w_wr_oob  = 1'b0;
   assign w_oob_evt = 1'b0;
`endif

   assign w_rd_idx  = i_rd_addr[AW-1:0];
   assign w_wr_idx  = i_wr_addr[AW-1:0];
   assign w_rd_go   = w_rd_fire & ~w_rd_oob;
   assign w_wr_go   = w_wr_fire & ~w_wr_oob;
   assign w_cnt_inc = w_wr_go ? sat_inc16(r_wr_cnt) : r_wr_cnt;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bank
         logic w_is_rd;
         assign w_is_rd         = (r_bank_sel == 1'(gi));
         assign w_bank_en[gi]   = w_is_rd ? w_rd_go : w_wr_go;
         assign w_bank_we[gi]   = w_is_rd ? SramRead : SramWrite;
         assign w_bank_addr[gi] = w_is_rd ? w_rd_idx : w_wr_idx;

         fmap_bank #(
            .DEPTH (DEPTH),
            .AW    (AW),
            .DW    (DW)
         ) u_bank (
            .clk     (clk),
            .i_en    (w_bank_en[gi]),
            .i_we    (w_bank_we[gi]),
            .i_addr  (w_bank_addr[gi]),
            .i_wdata (i_wr_data),
            .o_rdata (w_bank_q[gi])
         );
      end
   endgenerate

   // Remember which bank produced the last read so a later swap cannot
   // change data that is already on the output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_bank <= 1'b0;
         r_rd_zero <= 1'b1;
      end else if (w_rd_fire) begin
         r_rd_bank <= r_bank_sel;
         r_rd_zero <= w_rd_oob;
      end
   end

   assign o_rd_data = r_rd_zero ? '0 : w_bank_q[r_rd_bank];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ACTIVE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_do_swap   = 1'b0;
      case (r_state)
         ACTIVE: begin
            if (i_swap) begin
               if (w_oob_evt) begin
                  w_state_nxt = SWAP_PEND;
               end else begin
                  w_do_swap = 1'b1;
               end
            end
         end
         SWAP_PEND: begin
            w_do_swap   = 1'b1;
            w_state_nxt = ACTIVE;
         end
         default: w_state_nxt = ACTIVE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bank_sel    <= 1'b0;
         r_swap_ack    <= 1'b0;
         r_wr_cnt      <= 16'd0;
         r_frame_words <= 16'd0;
         r_err_oob     <= 1'b0;
      end else begin
         r_swap_ack <= w_do_swap;
         if (w_oob_evt) begin
            r_err_oob <= 1'b1;
         end
         // A write committing in the swap cycle belongs to the closing frame.
         if (w_do_swap) begin
            r_bank_sel    <= ~r_bank_sel;
            r_frame_words <= w_cnt_inc;
            r_wr_cnt      <= 16'd0;
         end else begin
            r_wr_cnt <= w_cnt_inc;
         end
      end
   end

   assign o_swap_ack    = r_swap_ack;
   assign o_bank_sel    = r_bank_sel;
   assign o_frame_words = r_frame_words;
   assign o_err_oob     = r_err_oob;

endmodule
`default_nettype wire
